// File: rtl/wsp_sequencer.sv
// Wrapper serial port sequencer: turns one shift command into a SelectWIR /
// Capture / Shift / Update sequence on the WSC and returns the bits captured from WSO.
module wsp_sequencer #(
  parameter int MAX_LEN = 64
) (
  input  logic               WRCK,
  input  logic               RESET,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_wir,
  input  logic [6:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               SelectWIR,
  output logic               CaptureWR,
  output logic               ShiftWR,
  output logic               UpdateWR,
  output logic               WSI,
  input  logic               WSO
);

  typedef enum logic [2:0] {
    IDLE, SETUP, CAPTURE, SHIFT, UPDATE, DONE
  } state_t;

  localparam logic [6:0] LEN_CAP = 7'(MAX_LEN);

  state_t             state;
  logic [6:0]         cnt;
  logic [MAX_LEN-1:0] data_sr;
  logic [MAX_LEN-1:0] mask;
  logic [6:0]         eff_len;

  assign eff_len = (cmd_len > LEN_CAP) ? LEN_CAP : cmd_len;

  // Every output is loaded on the edge that enters the state it belongs to,
  // so the WSC lines are glitch-free flops and change together with the state.
  // NOTE: non-blocking assignments keep every flop reading pre-edge values,
  // which is what makes the state and its outputs move in lockstep.
  always_ff @(posedge WRCK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      SelectWIR <= 1'b0;
      CaptureWR <= 1'b0;
      ShiftWR   <= 1'b0;
      UpdateWR  <= 1'b0;
      WSI       <= 1'b0;
      cnt       <= '0;
      data_sr   <= '0;
      mask      <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            state     <= SETUP;
            cmd_ready <= 1'b0;
            SelectWIR <= cmd_wir;
            data_sr   <= cmd_data;
            cnt       <= eff_len;
            rsp_data  <= '0;
          end
        end
        SETUP: begin
          state     <= CAPTURE;
          CaptureWR <= 1'b1;
        end
        CAPTURE: begin
          CaptureWR <= 1'b0;
          if (cnt == '0) begin
            state    <= UPDATE;
            UpdateWR <= 1'b1;
          end else begin
            state   <= SHIFT;
            ShiftWR <= 1'b1;
            WSI     <= data_sr[0];
            data_sr <= data_sr >> 1;
            mask    <= MAX_LEN'(1);
          end
        end
        SHIFT: begin
          // mask is one-hot on the bit position of the current shift cycle
          rsp_data <= rsp_data | (mask & {MAX_LEN{WSO}});
          mask     <= mask << 1;
          cnt      <= cnt - 7'd1;
          if (cnt == 7'd1) begin
            state    <= UPDATE;
            ShiftWR  <= 1'b0;
            WSI      <= 1'b0;
            UpdateWR <= 1'b1;
          end else begin
            WSI     <= data_sr[0];
            data_sr <= data_sr >> 1;
          end
        end
        UPDATE: begin
          state     <= DONE;
          UpdateWR  <= 1'b0;
          SelectWIR <= 1'b0;
          rsp_valid <= 1'b1;
        end
        DONE: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wsp_sequencer.sv
// Self-checking bench for wsp_sequencer: directed vector table, reset/abort
// sequences and randomized commands against a cycle-indexed reference model.
module tb_wsp_sequencer;

  logic        WRCK = 1'b0;
  logic        RESET;
  logic        cmd_valid, cmd_ready, cmd_wir;
  logic [6:0]  cmd_len;
  logic [63:0] cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_data;
  logic        SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI, WSO;

  int checks = 0;
  int errors = 0;

  wsp_sequencer #(.MAX_LEN(64)) dut (
    .WRCK(WRCK), .RESET(RESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wir(cmd_wir),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .SelectWIR(SelectWIR), .CaptureWR(CaptureWR), .ShiftWR(ShiftWR),
    .UpdateWR(UpdateWR), .WSI(WSI), .WSO(WSO)
  );

  always #5 WRCK = ~WRCK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  typedef struct {
    logic        wir;
    logic [6:0]  len;
    logic [63:0] data;
    int          delay;
    logic        bypass;
    logic        hold;
    logic [63:0] exp_rsp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // {SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI, rsp_valid, cmd_ready}
  function automatic logic [6:0] outs();
    return {SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI, rsp_valid, cmd_ready};
  endfunction

  // Runs one command from a negedge in IDLE back to a negedge in IDLE.
  // loopback=1 drives WSO with WSI delayed by one shift (bypass bit first);
  // otherwise WSO is random every cycle.
  task automatic run_cmd(input logic wir, input logic [6:0] len, input logic [63:0] data,
                         input logic loopback, input int delay, input logic bypass,
                         input logic hold, output logic [63:0] rsp_got);
    int          l;
    int          n_sh;
    int          n_up;
    logic [63:0] exp_rsp;
    logic [6:0]  exp_o;
    logic        v;
    l       = (len > 7'd64) ? 64 : int'(len);
    n_sh    = 0;
    n_up    = 0;
    exp_rsp = '0;
    rsp_got = '0;
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_wir   = wir;
    cmd_len   = len;
    cmd_data  = data;
    @(negedge WRCK);
    if (!hold) cmd_valid = 1'b0;
    for (int t = 1; t <= l + 4 + delay; t++) begin
      automatic bit sh = (t >= 3) && (t <= l + 2);
      automatic int k  = t - 3;
      exp_o = {(t <= l + 3) ? wir : 1'b0, t == 2, sh, t == l + 3,
               sh ? data[k] : 1'b0, t >= l + 4, 1'b0};
      check("cycle_outputs", outs(), exp_o);
      n_sh += int'(ShiftWR);
      n_up += int'(UpdateWR);
      if (sh) begin
        v = loopback ? ((k == 0) ? bypass : data[k-1]) : 1'($urandom_range(0, 1));
        exp_rsp[k] = v;
      end else begin
        v = 1'($urandom_range(0, 1));
      end
      WSO = v;
      if (t >= l + 4) begin
        check("rsp_data_held", rsp_data, exp_rsp);
        rsp_got   = rsp_data;
        rsp_ready = (t - (l + 4)) >= delay;
      end
      @(negedge WRCK);
    end
    rsp_ready = 1'b0;
    check("back_to_idle", outs(), 7'b0000001);
    check("shift_count", n_sh, l);
    check("update_pulses", n_up, 1);
    if (hold) begin
      cmd_valid = 1'b0;
      @(negedge WRCK);
      check("no_queued_cmd", outs(), 7'b0000001);
    end
  endtask

  initial begin
    logic [63:0] got;

    vecs[0] = '{1'b1, 7'd3,   64'h5,                   0, 1'b0, 1'b0, 64'h2};
    vecs[1] = '{1'b0, 7'd8,   64'hA5,                  1, 1'b1, 1'b0, 64'h4B};
    vecs[2] = '{1'b0, 7'd0,   64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1, 1'b0, 64'h0};
    vecs[3] = '{1'b1, 7'd100, 64'hFFFF_FFFF_FFFF_FFFF, 5, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[4] = '{1'b0, 7'd64,  64'h0123_4567_89AB_CDEF, 2, 1'b1, 1'b0, 64'h0246_8ACF_1357_9BDF};
    vecs[5] = '{1'b1, 7'd1,   64'h0,                   0, 1'b1, 1'b1, 64'h1};
    vecs[6] = '{1'b0, 7'd65,  64'h8000_0000_0000_0001, 1, 1'b0, 1'b0, 64'h2};

    RESET     = 1'b1;
    cmd_valid = 1'b0;
    cmd_wir   = 1'b0;
    cmd_len   = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    WSO       = 1'b0;
    #2;
    check("reset_outputs", outs(), 7'b0);
    check("reset_rsp_data", rsp_data, 64'h0);
    @(negedge WRCK);
    @(negedge WRCK);
    RESET = 1'b0;
    @(negedge WRCK);
    check("ready_after_release", outs(), 7'b0000001);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].wir, vecs[i].len, vecs[i].data, 1'b1, vecs[i].delay,
              vecs[i].bypass, vecs[i].hold, got);
      check($sformatf("vec%0d_rsp", i), got, vecs[i].exp_rsp);
    end

    // Abort in shift cycle 10 of a 20-bit shift
    check("ready_before_abort", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_wir   = 1'b1;
    cmd_len   = 7'd20;
    cmd_data  = {$urandom, $urandom};
    WSO       = 1'b1;
    @(negedge WRCK);
    cmd_valid = 1'b0;
    repeat (12) @(negedge WRCK);
    check("abort_in_shift", ShiftWR, 1);
    RESET = 1'b1;
    #1;
    check("abort_outputs_clear", outs(), 7'b0);
    check("abort_rsp_clear", rsp_data, 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge WRCK);
      check("abort_held", outs(), 7'b0);
    end
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge WRCK);
      check("abort_idle_after", outs(), 7'b0000001);
    end

    for (int i = 0; i < 20; i++) begin
      run_cmd(1'($urandom_range(0, 1)), 7'($urandom_range(0, 70)), {$urandom, $urandom},
              1'b0, $urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wsp_sequencer.md
WSP_SEQUENCER -- requirements
Module: wsp_sequencer

Interface
REQ-001 Parameter MAX_LEN, default 64, maximum shift length in bits per command.
REQ-002 WRCK  input  1  wrapper clock; all state changes on the rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  sequencer can accept a command (high only in IDLE).
REQ-006 cmd_wir  input  1  1 = WIR operation, 0 = selected data register (WBY/WBR) operation.
REQ-007 cmd_len  input  7  number of shift cycles requested.
REQ-008 cmd_data  input  MAX_LEN  serial data to shift in, bit 0 first.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  result consumed.
REQ-011 rsp_data  output  MAX_LEN  bits captured from WSO, first bit in bit 0.
REQ-012 SelectWIR, CaptureWR, ShiftWR, UpdateWR  output  1 each  WSC control to the wrapped core.
REQ-013 WSI  output  1  wrapper serial input to the wrapped core.
REQ-014 WSO  input  1  wrapper serial output from the wrapped core.

Function
REQ-015 The FSM SHALL have states IDLE, SETUP, CAPTURE, SHIFT, UPDATE, DONE; all WSC outputs and WSI SHALL be registered.
REQ-016 A handshake (cmd_valid & cmd_ready at an edge) SHALL latch cmd_wir, the effective length and cmd_data, and move IDLE->SETUP.
REQ-017 Effective length SHALL be min(cmd_len, MAX_LEN); cmd_len=0 SHALL be legal and SHALL skip SHIFT.
REQ-018 SelectWIR SHALL equal the latched cmd_wir in SETUP, CAPTURE, SHIFT and UPDATE, and SHALL be 0 in IDLE and DONE.
REQ-019 SETUP SHALL last exactly one cycle, with all of CaptureWR, ShiftWR and UpdateWR low, so that SelectWIR settles first.
REQ-020 CAPTURE SHALL last one cycle with CaptureWR=1, then go to SHIFT, or to UPDATE if the length is 0.
REQ-021 SHIFT SHALL last exactly len cycles with ShiftWR=1; in shift cycle k (0-based), WSI SHALL equal latched data bit k.
REQ-022 At each rising edge that ends a cycle with ShiftWR=1, WSO SHALL be sampled into rsp_data bit k; rsp_data bits at and above len SHALL be 0.
REQ-023 A down-counter SHALL track remaining shift cycles; SHIFT->UPDATE SHALL occur on the edge where the count reaches 0, with no extra or missing shift cycle.
REQ-024 UPDATE SHALL last one cycle with UpdateWR=1, then go to DONE.
REQ-025 In DONE, rsp_valid=1 and rsp_data SHALL be held stable until rsp_ready=1 at an edge, then return to IDLE.
REQ-026 At most one of CaptureWR, ShiftWR and UpdateWR SHALL be high in any cycle.
REQ-027 WSI SHALL be 0 outside SHIFT.
REQ-028 cmd_valid outside IDLE SHALL be ignored; it SHALL not be queued.
REQ-029 Total latency from handshake to rsp_valid SHALL be len+4 cycles.

Reset
REQ-030 While RESET=1, asynchronously: state=IDLE, all WSC outputs, WSI and rsp_valid=0, rsp_data=0, counter=0; cmd_ready=1 from the first edge after release.
REQ-031 RESET asserted mid-operation SHALL abort with no UpdateWR pulse and no response.

Verification
REQ-032 WIR load: cmd_wir=1, len=3, data=3'b101 -> SelectWIR high 6 cycles; WSI sequence 1,0,1; one UpdateWR pulse; rsp_valid after 7 cycles.
REQ-033 WBY loop: cmd_wir=0, len=8, data=8'hA5, with WSO modelled as WSI delayed one shift -> rsp_data=8'h4A plus the captured bypass bit in bit 0.
REQ-034 len=0 -> SETUP, CAPTURE, UPDATE; ShiftWR never high; rsp_data=0; rsp_valid 4 cycles after handshake.
REQ-035 len=100 -> exactly 64 ShiftWR cycles; rsp_valid hold with rsp_ready=0 for 5 cycles keeps rsp_data stable.
REQ-036 RESET pulse during shift cycle 10 of 20 -> outputs clear immediately; no UpdateWR; cmd_ready=1 after release.
REQ-037 cmd_valid held high during an operation -> only one command is executed; the next is accepted only after DONE->IDLE.
